// File: rtl/aes_top.sv
// ---------------------------------------------------------------------------
// aes_top -- iterative AES-128 encryption core, one round per clock.
//
// A start request in IDLE loads AES_data_in ^ AES_key_in (initial
// AddRoundKey) and the cipher key. Nine full rounds follow, then a final
// round without MixColumns writes the ciphertext register and pulses
// AES_data_out_valid for one cycle. Round keys are expanded on the fly,
// one schedule step per round, alongside the data path.
//
// Handshake: AES_en is a level-sensitive request, sampled only in IDLE.
// While BUSY, AES_en, AES_data_in and AES_key_in are ignored. Valid rises
// 10 clocks after the load edge, lasts exactly one cycle, and the core is
// back in IDLE on that same edge, so AES_en held high restarts at once
// (one result every 11 cycles).
//
// Ports:
//   AES_clk             rising-edge clock
//   AES_rst_n           asynchronous active-low reset (aborts any operation)
//   AES_en              start request
//   AES_data_in[127:0]  plaintext, bits [127:120] = byte 0
//   AES_key_in[127:0]   cipher key, same byte order
//   AES_data_out[127:0] ciphertext register, held until next completion
//   AES_data_out_valid  one-cycle completion pulse
// ---------------------------------------------------------------------------
module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    // FIPS-197 S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_out_q, data_out_d;
    logic         valid_q, valid_d;

    // ---------------- data path: SubBytes, ShiftRows, MixColumns ----------
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [127:0] sr_w;
    logic [127:0] mc_w;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state_q[127-8*i -: 8]);
    end

    // Byte index is row + 4*column; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[r+4*c] = sb[r+4*((c+r)%4)];
        end
        assign sr_w[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
        assign mc_w[127-32*c -: 32] = {
            xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3],
            sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3],
            sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3],
            xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3])
        };
    end

    // ---------------- key schedule: one step per round ---------------------
    logic [31:0]  ks_t, ks_w0, ks_w1, ks_w2, ks_w3;
    logic [127:0] key_next;

    // RotWord then SubWord of the last word, plus this round's Rcon.
    assign ks_t = {sbox(key_q[23:16]), sbox(key_q[15:8]),
                   sbox(key_q[7:0]),   sbox(key_q[31:24])} ^ {rcon(round_q), 24'h0};
    assign ks_w0    = key_q[127:96] ^ ks_t;
    assign ks_w1    = key_q[95:64]  ^ ks_w0;
    assign ks_w2    = key_q[63:32]  ^ ks_w1;
    assign ks_w3    = key_q[31:0]   ^ ks_w2;
    assign key_next = {ks_w0, ks_w1, ks_w2, ks_w3};

    // ---------------- control -----------------------------------------------
    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        state_d    = state_q;
        key_d      = key_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (AES_en) begin
                    state_d = AES_data_in ^ AES_key_in;
                    key_d   = AES_key_in;
                    round_d = 4'd1;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                key_d = key_next;
                if (round_q == 4'd10) begin
                    data_out_d = sr_w ^ key_next;
                    valid_d    = 1'b1;
                    round_d    = 4'd0;
                    fsm_d      = IDLE;
                end else begin
                    state_d = mc_w ^ key_next;
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q      <= IDLE;
            round_q    <= 4'd0;
            state_q    <= 128'h0;
            key_q      <= 128'h0;
            data_out_q <= 128'h0;
            valid_q    <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            round_q    <= round_d;
            state_q    <= state_d;
            key_q      <= key_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_top.sv
// ---------------------------------------------------------------------------
// tb_aes_top -- self-checking bench for aes_top.
// Known-answer vectors, input scrambling while busy, back-to-back starts,
// asynchronous reset mid-operation, idle hold and random blocks compared
// against a byte-level AES-128 model whose S-box is derived from GF(2^8)
// inversion plus the affine transform.
// ---------------------------------------------------------------------------
module tb_aes_top;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         dval;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  sbox_m [256];
    logic [31:0] exp_q [$];
    int          got_q [$];

    aes_top dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (dval)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v} << k;
        return d[15:8];
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc = 8'h01;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]],
                       sbox_m[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One operation: pulse en for the load edge, wait (bounded) for valid,
    // check latency, ciphertext and that valid is gone on the next edge.
    task automatic run_op(input string tag, input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] exp, input bit scramble);
        int lat = 0;
        bit got = 0;
        en  = 1'b1;
        din = pt;
        kin = key;
        @(posedge clk); #1;
        en = 1'b0;
        while (!got && lat < 20) begin
            if (scramble) begin
                din = {$urandom, $urandom, $urandom, $urandom};
                kin = {$urandom, $urandom, $urandom, $urandom};
                en  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
            if (dval) got = 1;
        end
        en = 1'b0;
        chk($sformatf("%s_latency", tag), 128'(lat), 128'd10);
        chk($sformatf("%s_data", tag), dout, exp);
        @(posedge clk); #1;
        chk($sformatf("%s_valid_width", tag), 128'(dval), 128'd0);
    endtask

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] rp, rk, last;
        int pulses;

        rst_n = 1'b0;
        en    = 1'b0;
        din   = '0;
        kin   = '0;
        build_sbox();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", dout, 128'h0);
        chk("reset_valid", 128'(dval), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors
        run_op("fips_c1", P1, K1, C1, 1'b0);
        run_op("fips_b", P2, K2, C2, 1'b0);
        // Inputs changing every cycle while busy must not disturb the result
        run_op("zero_scramble", 128'h0, 128'h0, C0, 1'b1);

        // Back-to-back: en high over edges 0..43 gives loads at 0,11,22,33;
        // edge 44 sees en low so no fifth start.
        exp_q = {32'd10, 32'd21, 32'd32, 32'd43};
        got_q.delete();
        din = P1;
        kin = K1;
        for (int cyc = 0; cyc <= 70; cyc++) begin
            en = (cyc < 44);
            @(posedge clk); #1;
            if (dval) begin
                got_q.push_back(cyc);
                chk("b2b_data", dout, C1);
            end
        end
        en = 1'b0;
        chk("b2b_pulse_count", 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                chk($sformatf("b2b_pulse_cycle%0d", i), 128'(got_q[i]), 128'(exp_q[i]));

        // Idle hold after completion
        last = dout;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("idle_hold_data", dout, C1);
            chk("idle_hold_valid", 128'(dval), 128'd0);
        end

        // Asynchronous reset during round 5
        en  = 1'b1;
        din = {$urandom, $urandom, $urandom, $urandom};
        kin = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_data", dout, 128'h0);
        chk("async_reset_valid", 128'(dval), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (dval) pulses++;
        end
        chk("abort_no_valid", 128'(pulses), 128'd0);
        chk("abort_data_zero", dout, 128'h0);

        // Random blocks against the model
        for (int n = 0; n < 5; n++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_op($sformatf("random%0d", n), rp, rk, aes_model(rp, rk), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
